// File: rtl/serial_bit_feeder.sv
// Word-to-bit serializer: buffers parallel words in a small FIFO and shifts them out
// one bit per clock, back-to-back, with a pause control that freezes the shifter.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     pause,
    output logic                     x,
    output logic                     x_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {
        S_EMPTY,
        S_SHIFT
    } state_t;

    state_t            state, state_nx;
    logic [BW-1:0]     bcnt, bcnt_nx;
    logic [WIDTH-1:0]  shreg, shreg_nx;
    logic              x_nx, x_valid_nx;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop;
    logic [WIDTH-1:0]  head;

    // Bit index 0 is always the first bit on the wire, whatever the word order.
    function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic [BW-1:0] idx);
        logic [BW-1:0] pos;
        pos = MSB_FIRST ? (LAST_BIT - idx) : idx;
        return w[pos];
    endfunction

    assign din_ready  = !reset && (count < CW'(DEPTH));
    assign push       = din_valid && din_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign idle       = (state == S_EMPTY) && (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_EMPTY;
            bcnt    <= '0;
            shreg   <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            bcnt    <= bcnt_nx;
            shreg   <= shreg_nx;
            x       <= x_nx;
            x_valid <= x_valid_nx;
        end
    end

    // bcnt names the bit currently on x, so leaving pause simply resumes with the next one.
    always_comb begin
        state_nx   = state;
        bcnt_nx    = bcnt;
        shreg_nx   = shreg;
        x_nx       = 1'b0;
        x_valid_nx = 1'b0;
        pop        = 1'b0;
        if (!pause) begin
            case (state)
                S_EMPTY: begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_nx   = S_SHIFT;
                        shreg_nx   = head;
                        bcnt_nx    = '0;
                        x_nx       = pick_bit(head, '0);
                        x_valid_nx = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (bcnt == LAST_BIT) begin
                        if (count != '0) begin
                            pop        = 1'b1;
                            shreg_nx   = head;
                            bcnt_nx    = '0;
                            x_nx       = pick_bit(head, '0);
                            x_valid_nx = 1'b1;
                        end else begin
                            state_nx = S_EMPTY;
                            bcnt_nx  = '0;
                        end
                    end else begin
                        bcnt_nx    = bcnt + BW'(1);
                        x_nx       = pick_bit(shreg, bcnt + BW'(1));
                        x_valid_nx = 1'b1;
                    end
                end
                default: state_nx = S_EMPTY;
            endcase
        end
    end

endmodule
